rsp_id_restore: RTL and testbench
=================================

// Module: rsp_id_restore
// PURPOSE
//  Response-side counterpart of the slot allocator in the ROB path.
//  Read-response beats arrive tagged with a slot index (unique id).
//  This block looks up the original AXI ID bound to that slot and forwards the beat with the original ID restored.
//  On the last beat of a burst it frees the slot and pulses free_valid/free_idx back to the allocator.
//  It holds its own shadow table, written by the allocator's grant.
// PARAMETERS
//  ID_WIDTH         4   original AXI ID width
//  DATA_WIDTH       64  R-channel data width
//  MAX_OUTSTANDING  16  number of slots; localparam IDX_W = $clog2(MAX_OUTSTANDING)
// PORTS
//  clk              in   1           clock
//  rst              in   1           synchronous, active-high reset
//  alloc_valid      in   1           allocator grant: bind alloc_id to alloc_idx
//  alloc_idx        in   IDX_W       slot being bound
//  alloc_id         in   ID_WIDTH    original ID for that slot
//  s_rvalid         in   1           tagged response beat valid
//  s_rready         out  1           beat accepted when s_rvalid && s_rready
//  s_rid            in   IDX_W       slot index of the beat
//  s_rdata          in   DATA_WIDTH  beat data
//  s_rresp          in   2           AXI RRESP
//  s_rlast          in   1           last beat of burst
//  m_rvalid         out  1           restored beat valid
//  m_rready         in   1           downstream ready
//  m_rid            out  ID_WIDTH    restored original ID
//  m_rdata          out  DATA_WIDTH  beat data
//  m_rresp          out  2           RRESP; forced 2'b10 on error
//  m_rlast          out  1           last beat
//  free_valid       out  1           one-cycle pulse: slot free_idx released
//  free_idx         out  IDX_W       released slot
//  err_unalloc      out  1           sticky: beat arrived for an unbound slot
//  outstanding_cnt  out  IDX_W+1     number of currently bound slots
// BEHAVIOUR
//  Reset:
//  - All table entries invalid, id = 0.
//  - m_rvalid = 0, m_rid/m_rdata/m_rresp/m_rlast = 0.
//  - free_valid = 0, free_idx = 0, err_unalloc = 0, outstanding_cnt = 0.
//  - A reset mid-burst drops any held beat; no free pulse is issued for it.
//  Table:
//  - alloc_valid sets entry[alloc_idx].valid = 1 and .id = alloc_id on the next edge.
//  - alloc to an already-valid slot: ignored and sets err_unalloc.
//  - Exception: alloc to a slot cleared in the same cycle is legal and wins (entry stays valid, new id).
//  Output stage (single register slice):
//  - s_rready = !m_rvalid || m_rready (combinational, no bubble), so throughput is 1 beat/cycle.
//  - Latency is 1 cycle from s-accept to m_rvalid.
//  - On accept: m_rid <= entry[s_rid].id; data/resp/last are copied; m_rvalid <= 1.
//  - m_rvalid stays high with all m_* stable until m_rready.
//  - If m_rready is high and there is no new accept, m_rvalid <= 0.
//  - Lookup happens at the accept edge, so a same-cycle alloc to s_rid is NOT visible to that beat.
//  Free:
//  - Accepted beat with s_rlast=1 on a valid slot: entry.valid <= 0.
//  - Next cycle free_valid = 1 and free_idx = s_rid, one cycle wide, coincident with that beat's m_rvalid.
//  - Non-last beats never free.
//  Unbound slot (entry invalid at accept):
//  - Beat is still forwarded with m_rid = 0 and m_rresp = 2'b10.
//  - err_unalloc <= 1 (sticky until rst).
//  - No free pulse and no count change.
//  outstanding_cnt:
//  - +1 on an effective alloc, -1 on an effective free, unchanged if both happen in the same cycle.
//  - Cannot exceed MAX_OUTSTANDING, since a duplicate alloc is ignored.
// TESTING
//  1. Bind alloc idx3->id 0xA, then a 1-beat rsp s_rid=3, rlast=1 -> next cycle m_rid=0xA, free_valid=1, free_idx=3; cnt 1->0.
//  2. Bind idx5->0x7, then a 4-beat burst with m_rready low on beat 2 for 3 cycles -> m_* held stable, all 4 beats m_rid=0x7, single free pulse after beat 4.
//  3. Rsp s_rid=9 to an unbound slot -> m_rid=0, m_rresp=2'b10, err_unalloc=1, no free_valid, cnt unchanged.
//  4. Bind all 16 slots -> cnt=16; alloc idx0 again -> ignored, err_unalloc=1; last beat on idx0 with same-cycle alloc idx0->0x3 -> entry valid with id 0x3, cnt stays 16.
//  5. Back-to-back last beats on idx1, idx2 with m_rready=1 -> 1 beat/cycle, free_idx 1 then 2 on consecutive cycles.
//  6. Assert rst while m_rvalid=1 with a held rlast beat -> next cycle m_rvalid=0, free_valid=0, cnt=0, all entries invalid.

Source files
------------

// File: rtl/rsp_id_restore.sv
// rsp_id_restore: restores the original AXI ID on tagged read-response beats.
// A shadow slot table is written by allocator grants. Each beat is looked up
// by slot index and passed through a single register slice. On the last beat
// of a burst the slot is released and reported back to the allocator.
module rsp_id_restore #(
  parameter  int ID_WIDTH        = 4,
  parameter  int DATA_WIDTH      = 64,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int IDX_W           = $clog2(MAX_OUTSTANDING)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [IDX_W-1:0]      alloc_idx,
  input  logic [ID_WIDTH-1:0]   alloc_id,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [IDX_W-1:0]      s_rid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [ID_WIDTH-1:0]   m_rid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rlast,
  output logic                  free_valid,
  output logic [IDX_W-1:0]      free_idx,
  output logic                  err_unalloc,
  output logic [IDX_W:0]        outstanding_cnt
);

  // Shadow table: one valid bit and one original ID per slot.
  logic [MAX_OUTSTANDING-1:0] entry_valid;
  logic [ID_WIDTH-1:0]        entry_id [MAX_OUTSTANDING];

  logic accept;
  logic hit;
  logic free_now;
  logic alloc_dup;
  logic alloc_eff;

  // Handshake and table decisions for the current cycle. The lookup uses the
  // table contents before this edge, so a same-cycle alloc is not seen by the
  // beat. An alloc to a slot being freed right now is legal and takes effect.
  always_comb begin
    s_rready  = !m_rvalid || m_rready;
    accept    = s_rvalid && s_rready;
    hit       = entry_valid[s_rid];
    free_now  = accept && s_rlast && hit;
    alloc_dup = alloc_valid && entry_valid[alloc_idx] &&
                !(free_now && (s_rid == alloc_idx));
    alloc_eff = alloc_valid && !alloc_dup;
  end

  // Slot table update: free first, then a granted alloc overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        entry_id[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (alloc_eff && (alloc_idx == IDX_W'(i))) begin
          entry_valid[i] <= 1'b1;
          entry_id[i]    <= alloc_id;
        end else if (free_now && (s_rid == IDX_W'(i))) begin
          entry_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Output register slice: capture on accept, drop valid once drained.
  // Beats for unbound slots still pass, with ID 0 and a SLVERR response.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_rvalid <= 1'b0;
      m_rid    <= '0;
      m_rdata  <= '0;
      m_rresp  <= 2'b00;
      m_rlast  <= 1'b0;
    end else if (accept) begin
      m_rvalid <= 1'b1;
      m_rid    <= hit ? entry_id[s_rid] : '0;
      m_rdata  <= s_rdata;
      m_rresp  <= hit ? s_rresp : 2'b10;
      m_rlast  <= s_rlast;
    end else if (m_rready) begin
      m_rvalid <= 1'b0;
    end
  end

  // Free pulse, sticky error flag and bound-slot counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_valid      <= 1'b0;
      free_idx        <= '0;
      err_unalloc     <= 1'b0;
      outstanding_cnt <= '0;
    end else begin
      free_valid <= free_now;
      if (free_now) begin
        free_idx <= s_rid;
      end
      if (alloc_dup || (accept && !hit)) begin
        err_unalloc <= 1'b1;
      end
      case ({alloc_eff, free_now})
        2'b10:   outstanding_cnt <= outstanding_cnt + (IDX_W+1)'(1);
        2'b01:   outstanding_cnt <= outstanding_cnt - (IDX_W+1)'(1);
        default: outstanding_cnt <= outstanding_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_rsp_id_restore.sv
// Testbench for rsp_id_restore: directed scenarios plus a randomized run,
// all checked against a slot-table reference model kept in the bench.
module tb_rsp_id_restore;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_idx;
  logic [3:0]  alloc_id;
  logic        s_rvalid;
  logic        s_rready;
  logic [3:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic [3:0]  m_rid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        free_valid;
  logic [3:0]  free_idx;
  logic        err_unalloc;
  logic [4:0]  outstanding_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  rsp_id_restore #(.ID_WIDTH(4), .DATA_WIDTH(64), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_id(alloc_id),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .free_valid(free_valid), .free_idx(free_idx),
    .err_unalloc(err_unalloc), .outstanding_cnt(outstanding_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running after 1ms, required to finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  bit          bound [16];
  logic [3:0]  bound_id [16];
  int          m_count;
  bit          m_err;
  logic        e_valid;
  logic [3:0]  e_rid;
  logic [63:0] e_data;
  logic [1:0]  e_resp;
  logic        e_last;
  logic        e_fv;
  logic [3:0]  e_fidx;

  // Advance the model by one clock using the inputs currently driven, then
  // move to 1 time unit after the rising edge.
  task automatic tick();
    bit acc, freed, granted;
    freed   = 0;
    granted = 0;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        bound[i]    = 0;
        bound_id[i] = '0;
      end
      m_count = 0; m_err = 0;
      e_valid = 0; e_rid = '0; e_data = '0; e_resp = '0; e_last = 0;
      e_fv = 0; e_fidx = '0;
    end else begin
      acc  = s_rvalid && (!e_valid || m_rready);
      e_fv = 0;
      if (acc) begin
        if (bound[s_rid]) begin
          e_rid  = bound_id[s_rid];
          e_resp = s_rresp;
          freed  = s_rlast;
        end else begin
          e_rid  = '0;
          e_resp = 2'b10;
          m_err  = 1;
        end
        e_data  = s_rdata;
        e_last  = s_rlast;
        e_valid = 1;
      end else if (m_rready) begin
        e_valid = 0;
      end
      if (alloc_valid) begin
        if (bound[alloc_idx] && !(freed && alloc_idx == s_rid)) m_err = 1;
        else granted = 1;
      end
      if (freed) begin
        bound[s_rid] = 0;
        m_count--;
        e_fv   = 1;
        e_fidx = s_rid;
      end
      if (granted) begin
        if (!bound[alloc_idx]) m_count++;
        bound[alloc_idx]    = 1;
        bound_id[alloc_idx] = alloc_id;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Observable state; payload only matters while valid, free_idx while pulsing.
  function automatic logic [82:0] dut_vec();
    return {m_rvalid, m_rvalid ? m_rid : 4'h0, m_rvalid ? m_rdata : 64'h0,
            m_rvalid ? m_rresp : 2'b00, m_rvalid & m_rlast,
            free_valid, free_valid ? free_idx : 4'h0, err_unalloc, outstanding_cnt};
  endfunction

  function automatic logic [82:0] exp_vec();
    return {e_valid, e_valid ? e_rid : 4'h0, e_valid ? e_data : 64'h0,
            e_valid ? e_resp : 2'b00, e_valid & e_last,
            e_fv, e_fv ? e_fidx : 4'h0, m_err, 5'(m_count)};
  endfunction

  task automatic idle();
    alloc_valid = 0; alloc_idx = '0; alloc_id = '0;
    s_rvalid = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 0;
    m_rready = 1;
  endtask

  task automatic beat(input logic [3:0] rid, input logic last);
    s_rvalid = 1; s_rid = rid; s_rlast = last;
    s_rdata = {$urandom, $urandom}; s_rresp = 2'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, free_valid, free_idx,
         err_unalloc, outstanding_cnt} !== 83'h0)
      $display("FAIL reset_outputs: got %h required 0", {m_rvalid, m_rid, m_rdata,
               m_rresp, m_rlast, free_valid, free_idx, err_unalloc, outstanding_cnt});
    else pass_cnt++;
    #1;
    chk_cnt++;
    if (s_rready !== 1'b1) $display("FAIL reset_s_rready: got %b required 1", s_rready);
    else pass_cnt++;
    $display("reset: outstanding_cnt=%0d m_rvalid=%b", outstanding_cnt, m_rvalid);
  endtask

  task automatic test_single_beat();
    idle();
    alloc_valid = 1; alloc_idx = 4'd3; alloc_id = 4'hA;
    tick();
    idle();
    chk_cnt++;
    if (outstanding_cnt !== 5'd1) $display("FAIL t1_cnt_bind: got %0d required 1", outstanding_cnt);
    else pass_cnt++;
    beat(4'd3, 1'b1);
    tick();
    idle();
    chk_cnt++;
    if ({m_rvalid, m_rid, free_valid, free_idx, outstanding_cnt} !== {1'b1, 4'hA, 1'b1, 4'd3, 5'd0})
      $display("FAIL t1_restore: got v=%b id=%h fv=%b fidx=%0d cnt=%0d required v=1 id=a fv=1 fidx=3 cnt=0",
               m_rvalid, m_rid, free_valid, free_idx, outstanding_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (dut_vec() !== exp_vec()) $display("FAIL t1_model: got %h required %h", dut_vec(), exp_vec());
    else pass_cnt++;
    $display("single_beat: m_rid=%h free_idx=%0d cnt=%0d", m_rid, free_idx, outstanding_cnt);
    tick();
  endtask

  task automatic test_burst_stall();
    int nbeat, hs, frees;
    bit acc;
    nbeat = 0; hs = 0; frees = 0;
    idle();
    alloc_valid = 1; alloc_idx = 4'd5; alloc_id = 4'h7;
    tick();
    for (int c = 0; c < 12; c++) begin
      idle();
      m_rready = !(c >= 2 && c < 5);
      if (nbeat < 4) beat(4'd5, nbeat == 3);
      acc = s_rvalid && (!e_valid || m_rready);
      if (m_rvalid && m_rready) hs++;
      tick();
      if (acc) nbeat++;
      if (free_valid) frees++;
      chk_cnt++;
      if (dut_vec() !== exp_vec()) $display("FAIL t2_model_c%0d: got %h required %h", c, dut_vec(), exp_vec());
      else pass_cnt++;
      if (m_rvalid) begin
        chk_cnt++;
        if (m_rid !== 4'h7) $display("FAIL t2_rid_c%0d: got %h required 7", c, m_rid);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (hs != 4 || frees != 1)
      $display("FAIL t2_counts: got beats=%0d frees=%0d required beats=4 frees=1", hs, frees);
    else pass_cnt++;
    $display("burst_stall: beats=%0d frees=%0d cnt=%0d", hs, frees, outstanding_cnt);
  endtask

  task automatic test_unbound();
    idle();
    beat(4'd9, 1'b1);
    tick();
    idle();
    chk_cnt++;
    if ({m_rvalid, m_rid, m_rresp, err_unalloc, free_valid, outstanding_cnt} !==
        {1'b1, 4'h0, 2'b10, 1'b1, 1'b0, 5'd0})
      $display("FAIL t3_unbound: got v=%b id=%h resp=%b err=%b fv=%b cnt=%0d required 1 0 10 1 0 0",
               m_rvalid, m_rid, m_rresp, err_unalloc, free_valid, outstanding_cnt);
    else pass_cnt++;
    $display("unbound: m_rid=%h m_rresp=%b err=%b", m_rid, m_rresp, err_unalloc);
    tick();
  endtask

  task automatic test_full_and_realloc();
    logic [3:0] ids [16];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ids[i] = 4'($urandom);
      alloc_valid = 1; alloc_idx = 4'(i); alloc_id = ids[i];
      tick();
    end
    idle();
    chk_cnt++;
    if (outstanding_cnt !== 5'd16 || err_unalloc !== 1'b0)
      $display("FAIL t4_full: got cnt=%0d err=%b required cnt=16 err=0", outstanding_cnt, err_unalloc);
    else pass_cnt++;
    alloc_valid = 1; alloc_idx = 4'd0; alloc_id = ~ids[0];
    tick();
    idle();
    chk_cnt++;
    if (outstanding_cnt !== 5'd16 || err_unalloc !== 1'b1)
      $display("FAIL t4_dup: got cnt=%0d err=%b required cnt=16 err=1", outstanding_cnt, err_unalloc);
    else pass_cnt++;
    beat(4'd0, 1'b1);
    alloc_valid = 1; alloc_idx = 4'd0; alloc_id = 4'h3;
    tick();
    idle();
    chk_cnt++;
    if ({m_rid, free_valid, free_idx, outstanding_cnt} !== {ids[0], 1'b1, 4'd0, 5'd16})
      $display("FAIL t4_swap: got id=%h fv=%b fidx=%0d cnt=%0d required id=%h fv=1 fidx=0 cnt=16",
               m_rid, free_valid, free_idx, outstanding_cnt, ids[0]);
    else pass_cnt++;
    beat(4'd0, 1'b1);
    tick();
    idle();
    chk_cnt++;
    if ({m_rid, m_rresp == 2'b10, outstanding_cnt} !== {4'h3, 1'b0, 5'd15})
      $display("FAIL t4_newid: got id=%h resp=%b cnt=%0d required id=3 resp!=10 cnt=15",
               m_rid, m_rresp, outstanding_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (dut_vec() !== exp_vec()) $display("FAIL t4_model: got %h required %h", dut_vec(), exp_vec());
    else pass_cnt++;
    $display("full_realloc: cnt=%0d new_id=%h", outstanding_cnt, m_rid);
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_valid = 1; alloc_idx = 4'd1; alloc_id = 4'h5;
    tick();
    alloc_idx = 4'd2; alloc_id = 4'h6;
    tick();
    for (int k = 1; k <= 2; k++) begin
      idle();
      beat(4'(k), 1'b1);
      #1;
      chk_cnt++;
      if (s_rready !== 1'b1) $display("FAIL t5_ready_%0d: got %b required 1", k, s_rready);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({m_rvalid, m_rid, free_valid, free_idx} !== {1'b1, 4'(4 + k), 1'b1, 4'(k)})
        $display("FAIL t5_beat_%0d: got v=%b id=%h fv=%b fidx=%0d required v=1 id=%h fv=1 fidx=%0d",
                 k, m_rvalid, m_rid, free_valid, free_idx, 4 + k, k);
      else pass_cnt++;
      $display("back_to_back: beat %0d free_idx=%0d m_rid=%h", k, free_idx, m_rid);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_midburst();
    idle();
    alloc_valid = 1; alloc_idx = 4'd4; alloc_id = 4'hC;
    tick();
    idle();
    m_rready = 0;
    beat(4'd4, 1'b1);
    tick();
    idle();
    m_rready = 0;
    tick();
    chk_cnt++;
    if ({m_rvalid, m_rlast, free_valid} !== 3'b110)
      $display("FAIL t6_held: got v=%b last=%b fv=%b required 1 1 0", m_rvalid, m_rlast, free_valid);
    else pass_cnt++;
    rst = 1;
    tick();
    rst = 0;
    chk_cnt++;
    if ({m_rvalid, free_valid, outstanding_cnt} !== {1'b0, 1'b0, 5'd0})
      $display("FAIL t6_rst: got v=%b fv=%b cnt=%0d required 0 0 0", m_rvalid, free_valid, outstanding_cnt);
    else pass_cnt++;
    idle();
    beat(4'd4, 1'b1);
    tick();
    idle();
    chk_cnt++;
    if ({m_rid, m_rresp, err_unalloc, free_valid} !== {4'h0, 2'b10, 1'b1, 1'b0})
      $display("FAIL t6_cleared: got id=%h resp=%b err=%b fv=%b required 0 10 1 0",
               m_rid, m_rresp, err_unalloc, free_valid);
    else pass_cnt++;
    $display("reset_midburst: m_rvalid after rst=0 err=%b", err_unalloc);
    tick();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      alloc_valid = ($urandom_range(0, 99) < 30);
      alloc_idx   = 4'($urandom);
      alloc_id    = 4'($urandom);
      m_rready    = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 60) beat(4'($urandom), $urandom_range(0, 99) < 40);
      #1;
      chk_cnt++;
      if (s_rready !== (!e_valid || m_rready)) begin
        $display("FAIL rnd_ready_c%0d: got %b required %b", c, s_rready, !e_valid || m_rready);
        bad++;
      end else pass_cnt++;
      tick();
      chk_cnt++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL rnd_model_c%0d: got %h required %h", c, dut_vec(), exp_vec());
        bad++;
      end else pass_cnt++;
    end
    $display("random: 400 cycles, %0d mismatching comparisons, final cnt=%0d", bad, outstanding_cnt);
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_single_beat();
    test_burst_stall();
    test_unbound();
    test_full_and_realloc();
    test_back_to_back();
    test_reset_midburst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
